// File: rtl/key_input.sv
// key_input: push-button front end for the digital clock.
//
// Synchronises and debounces the raw MODE and INC buttons, owns the mode_flag
// (0 normal, 1 set second, 2 set minute, 3 set hour) and produces one-cycle
// increment requests with auto-repeat while INC is held.
//
// Ports:
//   clk100khz   in   system clock
//   rst_n       in   asynchronous active-low reset
//   key_mode_n  in   raw MODE button, active-low, asynchronous
//   key_inc_n   in   raw INC button, active-low, asynchronous
//   mode_flag   out  current mode, 0..3
//   mode_pulse  out  one-cycle strobe when mode_flag advances
//   inc_pulse   out  one-cycle increment request for the field being set

module key_input #(
    parameter int unsigned DEBOUNCE_CNT  = 1000,
    parameter int unsigned REPEAT_DELAY  = 50000,
    parameter int unsigned REPEAT_PERIOD = 10000
) (
    input  logic       clk100khz,
    input  logic       rst_n,
    input  logic       key_mode_n,
    input  logic       key_inc_n,
    output logic [1:0] mode_flag,
    output logic       mode_pulse,
    output logic       inc_pulse
);

    localparam int unsigned DbW    = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
    localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                    : REPEAT_PERIOD;
    localparam int unsigned RepW   = (RepMax > 1) ? $clog2(RepMax) : 1;

    localparam logic [DbW-1:0]  DbLast     = DbW'(DEBOUNCE_CNT - 1);
    localparam logic [RepW-1:0] DelayLast  = RepW'(REPEAT_DELAY - 1);
    localparam logic [RepW-1:0] PeriodLast = RepW'(REPEAT_PERIOD - 1);

    // Bit 0 = MODE, bit 1 = INC.
    logic [1:0] raw_keys;
    logic [1:0] key_level;   // debounced level, 1 = released
    logic [1:0] key_press;   // debounced 1->0 transition, valid for one cycle

    assign raw_keys = {key_inc_n, key_mode_n};

    // ------------------------------------------------------------------
    // Per-key synchroniser + debouncer
    // ------------------------------------------------------------------
    for (genvar k = 0; k < 2; k++) begin : g_key
        logic           sync1_q;
        logic           sync2_q;
        logic           stable_q;
        logic           stable_d;
        logic           prev_q;
        logic [DbW-1:0] cnt_q;
        logic [DbW-1:0] cnt_d;

        // The counter only runs while the synced level disagrees with the
        // stable level; any agreement restarts the qualification window.
        always_comb begin
            stable_d = stable_q;
            cnt_d    = '0;
            if (sync2_q != stable_q) begin
                if (cnt_q == DbLast) begin
                    stable_d = sync2_q;
                end else begin
                    cnt_d = cnt_q + DbW'(1);
                end
            end
        end

        always_ff @(posedge clk100khz or negedge rst_n) begin
            if (!rst_n) begin
                sync1_q  <= 1'b1;
                sync2_q  <= 1'b1;
                stable_q <= 1'b1;
                prev_q   <= 1'b1;
                cnt_q    <= '0;
            end else begin
                sync1_q  <= raw_keys[k];
                sync2_q  <= sync1_q;
                stable_q <= stable_d;
                prev_q   <= stable_q;
                cnt_q    <= cnt_d;
            end
        end

        assign key_level[k] = stable_q;
        assign key_press[k] = prev_q & ~stable_q;
    end

    // ------------------------------------------------------------------
    // Mode register and INC auto-repeat FSM
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        StIdle,
        StDelay,
        StRepeat,
        StLock
    } state_e;

    state_e          state_q, state_d;
    logic [RepW-1:0] rep_cnt_q, rep_cnt_d;
    logic [1:0]      mode_flag_q, mode_flag_d;
    logic            mode_pulse_q, mode_pulse_d;
    logic            inc_pulse_q, inc_pulse_d;

    logic mode_ev;
    logic inc_ev;
    logic inc_released;

    assign mode_ev      = key_press[0];
    assign inc_ev       = key_press[1];
    assign inc_released = key_level[1];

    always_comb begin
        state_d      = state_q;
        rep_cnt_d    = rep_cnt_q;
        mode_flag_d  = mode_flag_q;
        mode_pulse_d = 1'b0;
        inc_pulse_d  = 1'b0;

        if (mode_ev) begin
            mode_flag_d  = mode_flag_q + 2'd1;
            mode_pulse_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (inc_ev) begin
                    // MODE wins a simultaneous press; normal mode never increments.
                    if (mode_ev || (mode_flag_q == 2'd0)) begin
                        state_d = StLock;
                    end else begin
                        state_d     = StDelay;
                        inc_pulse_d = 1'b1;
                        rep_cnt_d   = '0;
                    end
                end
            end
            StDelay: begin
                if (inc_released) begin
                    state_d   = StIdle;
                    rep_cnt_d = '0;
                end else if (mode_ev) begin
                    state_d   = StLock;
                    rep_cnt_d = '0;
                end else if (rep_cnt_q == DelayLast) begin
                    state_d     = StRepeat;
                    inc_pulse_d = 1'b1;
                    rep_cnt_d   = '0;
                end else begin
                    rep_cnt_d = rep_cnt_q + RepW'(1);
                end
            end
            StRepeat: begin
                if (inc_released) begin
                    state_d   = StIdle;
                    rep_cnt_d = '0;
                end else if (mode_ev) begin
                    state_d   = StLock;
                    rep_cnt_d = '0;
                end else if (rep_cnt_q == PeriodLast) begin
                    inc_pulse_d = 1'b1;
                    rep_cnt_d   = '0;
                end else begin
                    rep_cnt_d = rep_cnt_q + RepW'(1);
                end
            end
            StLock: begin
                // Wait for release so the next increment needs a fresh press.
                if (inc_released) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d   = StIdle;
                rep_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk100khz or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            rep_cnt_q    <= '0;
            mode_flag_q  <= 2'd0;
            mode_pulse_q <= 1'b0;
            inc_pulse_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            rep_cnt_q    <= rep_cnt_d;
            mode_flag_q  <= mode_flag_d;
            mode_pulse_q <= mode_pulse_d;
            inc_pulse_q  <= inc_pulse_d;
        end
    end

    assign mode_flag  = mode_flag_q;
    assign mode_pulse = mode_pulse_q;
    assign inc_pulse  = inc_pulse_q;

endmodule
